univ_shift_reg: RTL and testbench

- Parametrised universal shift register; successor to the team's fixed 4-bit load/shift-left/shift-right register.
- Adds generic width, multi-position shifts of a programmable count, rotate and arithmetic modes, and a start/busy/done handshake.
- Sits behind the top-level pin wrapper, so configuration and data can arrive over the dedicated input pins and parallel state appears on the outputs.

---
 rtl/univ_shift_reg.sv | 167 ++++++++++++++++
 tb/tb_univ_shift_reg.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - parametrised universal shift register with start/busy/done handshake
//
// Purpose:
//   Holds a WIDTH-bit register that can be parallel-loaded or stepped a
//   programmable number of single-bit positions in one of five modes
//   (SHR, SHL, ROR, ROL, ASR). Modes 5-7 are reserved and step as no-ops
//   so the handshake timing is the same for every mode code.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous active-low reset
//   load       in   1        parallel-load request, honoured only in IDLE
//   load_data  in   WIDTH    value written by load
//   start      in   1        begin a shift operation, honoured only in IDLE
//   mode       in   3        operation code, sampled with start
//   amount     in   CNT_W    number of single-bit steps, sampled with start
//   ser_in     in   1        serial fill bit, sampled on every step
//   q          out  WIDTH    register contents
//   ser_out    out  1        last bit shifted or rotated out
//   busy       out  1        high while stepping
//   done       out  1        one-cycle completion pulse

module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] MODE_SHR = 3'd0;
    localparam logic [2:0] MODE_SHL = 3'd1;
    localparam logic [2:0] MODE_ROR = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ASR = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ser_out_q, ser_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Result of one single-bit step of the latched mode applied to q_q.
    logic [WIDTH-1:0] step_q;
    logic             step_ser;

    always_comb begin
        step_q   = q_q;
        step_ser = ser_out_q;
        case (mode_q)
            MODE_SHR: begin
                step_q   = {ser_in, q_q[WIDTH-1:1]};
                step_ser = q_q[0];
            end
            MODE_SHL: begin
                step_q   = {q_q[WIDTH-2:0], ser_in};
                step_ser = q_q[WIDTH-1];
            end
            MODE_ROR: begin
                step_q   = {q_q[0], q_q[WIDTH-1:1]};
                step_ser = q_q[0];
            end
            MODE_ROL: begin
                step_q   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                step_ser = q_q[WIDTH-1];
            end
            MODE_ASR: begin
                step_q   = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                step_ser = q_q[0];
            end
            default: begin
                // Reserved codes: register and serial output hold.
                step_q   = q_q;
                step_ser = ser_out_q;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mode_d    = mode_q;
        q_d       = q_q;
        ser_out_d = ser_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    // Load wins over a simultaneous start.
                    q_d = load_data;
                end else if (start) begin
                    if (amount == '0) begin
                        // Zero-length operation completes immediately
                        // without ever raising busy.
                        done_d = 1'b1;
                    end else begin
                        mode_d  = mode;
                        count_d = amount;
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                q_d       = step_q;
                ser_out_d = step_ser;
                count_d   = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            mode_q    <= '0;
            q_q       <= '0;
            ser_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            q_q       <= q_d;
            ser_out_q <= ser_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign q       = q_q;
    assign ser_out = ser_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed self-checking bench for univ_shift_reg

module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;

    int vectors;
    int miscompares;

    univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .start     (start),
        .mode      (mode),
        .amount    (amount),
        .ser_in    (ser_in),
        .q         (q),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load      = 1'b1;
        load_data = v;
        tick();
        load      = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] m, input logic [CNT_W-1:0] a);
        start  = 1'b1;
        mode   = m;
        amount = a;
        tick();
        start  = 1'b0;
    endtask

    // Count cycles with busy high, bounded; returns at the first non-busy cycle.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        load      = 1'b1;
        load_data = 8'hFF;
        start     = 1'b1;
        mode      = 3'd1;
        amount    = 4'd3;
        tick();
        tick();
        load  = 1'b0;
        start = 1'b0;
        vectors++; if (q !== 8'h00) begin miscompares++; $display("FAIL reset_q: got %h want 00", q); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (ser_out !== 1'b0) begin miscompares++; $display("FAIL reset_ser_out: got %b want 0", ser_out); end
        rst_n = 1'b1;
        tick();
        vectors++; if (q !== 8'h00 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_release: q %h busy %b want 00 0", q, busy); end
    endtask

    task automatic test_shl();
        logic [7:0] exp_q [3];
        logic       exp_s [3];
        exp_q[0] = 8'h4A; exp_q[1] = 8'h94; exp_q[2] = 8'h28;
        exp_s[0] = 1'b1;  exp_s[1] = 1'b0;  exp_s[2] = 1'b1;
        ser_in = 1'b0;
        do_load(8'hA5);
        vectors++; if (q !== 8'hA5) begin miscompares++; $display("FAIL shl_load: got %h want a5", q); end
        do_start(3'd1, 4'd3);
        vectors++; if (busy !== 1'b1 || q !== 8'hA5) begin miscompares++; $display("FAIL shl_accept: busy %b q %h want 1 a5", busy, q); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (q !== exp_q[i]) begin miscompares++; $display("FAIL shl_step%0d_q: got %h want %h", i, q, exp_q[i]); end
            vectors++; if (ser_out !== exp_s[i]) begin miscompares++; $display("FAIL shl_step%0d_ser: got %b want %b", i, ser_out, exp_s[i]); end
            vectors++;
            if (busy !== (i < 2) || done !== (i == 2)) begin
                miscompares++; $display("FAIL shl_step%0d_hs: busy %b done %b want %b %b", i, busy, done, (i < 2), (i == 2));
            end
        end
        tick();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL shl_done_width: got %b want 0", done); end
    endtask

    task automatic test_rotate();
        int n;
        do_load(8'h81);
        do_start(3'd2, 4'd1);
        wait_idle(n);
        vectors++; if (n != 1) begin miscompares++; $display("FAIL ror_busy_cycles: got %0d want 1", n); end
        vectors++; if (q !== 8'hC0 || ser_out !== 1'b1) begin miscompares++; $display("FAIL ror_result: q %h ser %b want c0 1", q, ser_out); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL ror_done: got %b want 1", done); end
        do_start(3'd3, 4'd9);
        wait_idle(n);
        vectors++; if (n != 9) begin miscompares++; $display("FAIL rol9_busy_cycles: got %0d want 9", n); end
        vectors++; if (q !== 8'h81 || ser_out !== 1'b1) begin miscompares++; $display("FAIL rol9_result: q %h ser %b want 81 1", q, ser_out); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rol9_done: got %b want 1", done); end
    endtask

    task automatic test_asr_shr();
        int n;
        ser_in = 1'b1;
        do_load(8'h80);
        do_start(3'd4, 4'd7);
        wait_idle(n);
        vectors++; if (n != 7) begin miscompares++; $display("FAIL asr_busy_cycles: got %0d want 7", n); end
        vectors++; if (q !== 8'hFF || ser_out !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL asr_result: q %h ser %b done %b want ff 0 1", q, ser_out, done); end
        do_load(8'h00);
        do_start(3'd0, 4'd8);
        wait_idle(n);
        vectors++; if (n != 8) begin miscompares++; $display("FAIL shr_busy_cycles: got %0d want 8", n); end
        vectors++; if (q !== 8'hFF || ser_out !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL shr_result: q %h ser %b done %b want ff 0 1", q, ser_out, done); end
        ser_in = 1'b0;
    endtask

    task automatic test_zero_and_priority();
        do_load(8'h3C);
        do_start(3'd1, 4'd0);
        vectors++; if (busy !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL zero_hs: busy %b done %b want 0 1", busy, done); end
        vectors++; if (q !== 8'h3C || ser_out !== 1'b0) begin miscompares++; $display("FAIL zero_hold: q %h ser %b want 3c 0", q, ser_out); end
        tick();
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL zero_after: busy %b done %b want 0 0", busy, done); end
        load      = 1'b1;
        load_data = 8'h5A;
        do_start(3'd1, 4'd3);
        load      = 1'b0;
        vectors++; if (q !== 8'h5A || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL load_wins: q %h busy %b done %b want 5a 0 0", q, busy, done); end
        tick();
        vectors++; if (q !== 8'h5A || busy !== 1'b0) begin miscompares++; $display("FAIL load_wins_after: q %h busy %b want 5a 0", q, busy); end
    endtask

    task automatic test_abort();
        ser_in = 1'b0;
        do_load(8'h01);
        do_start(3'd1, 4'd5);
        tick();
        vectors++; if (q !== 8'h02 || busy !== 1'b1) begin miscompares++; $display("FAIL abort_step1: q %h busy %b want 02 1", q, busy); end
        load      = 1'b1;
        load_data = 8'hFF;
        tick();
        load      = 1'b0;
        vectors++; if (q !== 8'h04 || busy !== 1'b1) begin miscompares++; $display("FAIL busy_load_ignored: q %h busy %b want 04 1", q, busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
            miscompares++; $display("FAIL abort_reset: q %h busy %b done %b ser %b want 00 0 0 0", q, busy, done, ser_out);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_no_done%0d: busy %b done %b want 0 0", i, busy, done); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        ser_in = 1'b1;
        do_load(8'h55);
        do_start(3'd6, 4'd2);
        wait_idle(n);
        vectors++; if (n != 2) begin miscompares++; $display("FAIL rsvd_busy_cycles: got %0d want 2", n); end
        vectors++; if (q !== 8'h55 || ser_out !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL rsvd_result: q %h ser %b done %b want 55 0 1", q, ser_out, done); end
        ser_in = 1'b0;
        do_start(3'd1, 4'd1);
        vectors++; if (busy !== 1'b1 || done !== 1'b0 || q !== 8'h55) begin miscompares++; $display("FAIL b2b_accept: busy %b done %b q %h want 1 0 55", busy, done, q); end
        tick();
        vectors++; if (q !== 8'hAA || done !== 1'b1 || busy !== 1'b0 || ser_out !== 1'b0) begin
            miscompares++; $display("FAIL b2b_result: q %h done %b busy %b ser %b want aa 1 0 0", q, done, busy, ser_out);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        load        = 1'b0;
        load_data   = '0;
        start       = 1'b0;
        mode        = '0;
        amount      = '0;
        ser_in      = 1'b0;
        test_reset();
        test_shl();
        test_rotate();
        test_asr_shr();
        test_zero_and_priority();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
